axis_pkt_len_check: RTL

//  Downstream consumer of the 2-clock AXIS buffer's post-side stream. Single clock domain.

---
 rtl/axis_pkt_len_check.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axis_pkt_len_check.sv
// AXI-stream packet length checker with a registered skid stage.
// Optional data pattern check is enabled by defining PATTERN_CHECK_EN.
module axis_pkt_len_check #(
  parameter int DATA_W = 8,
  parameter int USER_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_in_axis_data,
  input  logic [USER_W-1:0] i_in_axis_user,
  input  logic              i_in_axis_valid,
  input  logic              i_in_axis_last,
  output logic              o_in_axis_ready,
  output logic [DATA_W-1:0] o_out_axis_data,
  output logic [USER_W-1:0] o_out_axis_user,
  output logic              o_out_axis_valid,
  output logic              o_out_axis_last,
  input  logic              i_out_axis_ready,
  output logic              o_pkt_done,
  output logic [1:0]        o_pkt_err,
  output logic [CNT_W-1:0]  o_pkt_len,
  output logic [CNT_W-1:0]  o_good_cnt,
  output logic [CNT_W-1:0]  o_bad_cnt
);

  localparam int MW = (USER_W > CNT_W) ? USER_W : CNT_W;

  typedef enum logic {
    IDLE,
    BODY
  } state_t;

  state_t             state;
  logic               hs;
  logic               first;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [USER_W-1:0]  len_exp;
  logic [USER_W-1:0]  len_nxt;
  logic               len_bad;
  logic               pat_bad;

  logic [DATA_W-1:0]  skid_data;
  logic [USER_W-1:0]  skid_user;
  logic               skid_last;
  logic               skid_valid;

  assign hs      = i_in_axis_valid & o_in_axis_ready;
  assign first   = (state == IDLE);
  assign cnt_nxt = first ? CNT_W'(1)
                 : (&cnt ? cnt : cnt + CNT_W'(1));
  assign len_nxt = first ? i_in_axis_user : len_exp;
  assign len_bad = MW'(cnt_nxt) != MW'(len_nxt);

`ifdef PATTERN_CHECK_EN
  logic [DATA_W-1:0] pat_exp;
  logic [DATA_W-1:0] pat_cur;
  logic              pat_acc;

  assign pat_cur = first ? DATA_W'(1) : pat_exp;
  assign pat_bad = (i_in_axis_data != pat_cur)
                 | (!first & pat_acc);

  // Track the expected incrementing data value and sticky mismatch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pat_exp <= '0;
      pat_acc <= 1'b0;
    end else if (hs) begin
      pat_exp <= pat_cur + DATA_W'(1);
      pat_acc <= pat_bad;
    end
  end
`else
  assign pat_bad = 1'b0;
`endif

  // Output register plus one skid entry; ready drops only while skid is full.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_out_axis_valid <= 1'b0;
      o_out_axis_data  <= '0;
      o_out_axis_user  <= '0;
      o_out_axis_last  <= 1'b0;
      skid_valid       <= 1'b0;
      skid_data        <= '0;
      skid_user        <= '0;
      skid_last        <= 1'b0;
      o_in_axis_ready  <= 1'b1;
    end else if (!o_out_axis_valid || i_out_axis_ready) begin
      if (skid_valid) begin
        o_out_axis_valid <= 1'b1;
        o_out_axis_data  <= skid_data;
        o_out_axis_user  <= skid_user;
        o_out_axis_last  <= skid_last;
        skid_valid       <= 1'b0;
        o_in_axis_ready  <= 1'b1;
      end else begin
        o_out_axis_valid <= hs;
        if (hs) begin
          o_out_axis_data <= i_in_axis_data;
          o_out_axis_user <= i_in_axis_user;
          o_out_axis_last <= i_in_axis_last;
        end
      end
    end else if (hs) begin
      skid_valid      <= 1'b1;
      skid_data       <= i_in_axis_data;
      skid_user       <= i_in_axis_user;
      skid_last       <= i_in_axis_last;
      o_in_axis_ready <= 1'b0;
    end
  end

  // Packet FSM: count beats, report status and update counters on last.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      len_exp    <= '0;
      o_pkt_done <= 1'b0;
      o_pkt_err  <= 2'b00;
      o_pkt_len  <= '0;
      o_good_cnt <= '0;
      o_bad_cnt  <= '0;
    end else begin
      o_pkt_done <= 1'b0;
      if (hs) begin
        cnt     <= cnt_nxt;
        len_exp <= len_nxt;
        if (i_in_axis_last) begin
          state      <= IDLE;
          o_pkt_done <= 1'b1;
          o_pkt_err  <= {pat_bad, len_bad};
          o_pkt_len  <= cnt_nxt;
          if (len_bad | pat_bad) begin
            if (!(&o_bad_cnt))
              o_bad_cnt <= o_bad_cnt + CNT_W'(1);
          end else begin
            if (!(&o_good_cnt))
              o_good_cnt <= o_good_cnt + CNT_W'(1);
          end
        end else begin
          state <= BODY;
        end
      end
    end
  end

endmodule
